ddr2_local_test_master: RTL and testbench

Traffic-generating master for the DDR2 controller's local (user) interface in the DDR test design. It sits on the controller's `phy_clk` domain and drives `local_*` requests into the controller. It writes an address-derived pattern over a configurable window, then reads the window back with pipelined reads and checks every returned word. It reports busy/done/pass, a saturating error count and the first failing address to the board-level status logic (LEDs/UART).

---
 rtl/ddr2_local_test_master.sv | 191 +++++++++++++++++++
 tb/tb_ddr2_local_test_master.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_local_test_master.sv
// DDR2 local-interface traffic master: writes an address-derived
// pattern over a window, reads it back and counts mismatching words.
module ddr2_local_test_master #(
  parameter int unsigned       ADDR_W    = 26,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       BURST_LEN = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       N_WORDS   = 1024,
  parameter int unsigned       MAX_OUTST = 8,
  parameter logic [31:0]       SEED      = 32'h5A5A_0000
) (
  input  logic              phy_clk,
  input  logic              reset_phy_clk_n,
  input  logic              start,
  input  logic              local_init_done,
  input  logic              local_ready,
  input  logic [DATA_W-1:0] local_rdata,
  input  logic              local_rdata_valid,
  output logic [ADDR_W-1:0] local_address,
  output logic              local_write_req,
  output logic              local_read_req,
  output logic              local_burstbegin,
  output logic [2:0]        local_size,
  output logic [3:0]        local_be,
  output logic [DATA_W-1:0] local_wdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int CW = $clog2(N_WORDS + 1);
  localparam int OW = $clog2(MAX_OUTST + BURST_LEN + 1) + 1;
  localparam logic [CW-1:0] LAST_W = CW'(N_WORDS - 1);
  localparam logic [CW-1:0] LAST_R = CW'(N_WORDS - BURST_LEN);
  localparam logic [CW-1:0] BL_C   = CW'(BURST_LEN);
  localparam logic [1:0]    BEAT_L = 2'(BURST_LEN - 1);
  localparam logic [OW-1:0] BL_O   = OW'(BURST_LEN);
  localparam logic [OW-1:0] MAX_O  = OW'(MAX_OUTST);

  typedef enum logic [2:0] {
    IDLE, WAIT_INIT, WRITE, READ, DRAIN, DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     woff;
  logic [CW-1:0]     roff;
  logic [CW-1:0]     coff;
  logic [1:0]        beat;
  logic [OW-1:0]     outst;
  logic [OW-1:0]     outst_nx;
  logic              mm_q;
  logic [ADDR_W-1:0] mm_addr;
  logic              wr_acc;
  logic              rd_acc;
  logic              rv;
  logic              rd_ok;

  function automatic logic [ADDR_W-1:0] waddr(input logic [CW-1:0] off);
    return BASE_ADDR + ADDR_W'(off);
  endfunction

  function automatic logic [DATA_W-1:0] pat(input logic [CW-1:0] off);
    logic [ADDR_W-1:0] a;
    a = waddr(off);
    return DATA_W'({~a[15:0], a[15:0]} ^ SEED);
  endfunction

  always_comb begin
    wr_acc   = local_write_req && local_ready;
    rd_acc   = local_read_req && local_ready;
    rv       = local_rdata_valid && (outst != '0)
               && (state == READ || state == DRAIN);
    outst_nx = outst + (rd_acc ? BL_O : '0) - (rv ? OW'(1) : '0);
    // cap is judged on the count seen while the request is presented
    rd_ok    = (outst_nx + BL_O) <= MAX_O;
  end

  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      state            <= IDLE;
      woff             <= '0;
      roff             <= '0;
      coff             <= '0;
      beat             <= '0;
      outst            <= '0;
      mm_q             <= 1'b0;
      mm_addr          <= '0;
      local_address    <= '0;
      local_write_req  <= 1'b0;
      local_read_req   <= 1'b0;
      local_burstbegin <= 1'b0;
      local_size       <= 3'(BURST_LEN);
      local_be         <= 4'hF;
      local_wdata      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_err_addr   <= '0;
    end else begin
      mm_q  <= 1'b0;
      outst <= outst_nx;
      if (rv) begin
        coff    <= coff + CW'(1);
        mm_q    <= local_rdata != pat(coff);
        mm_addr <= waddr(coff);
      end
      if (mm_q) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == '0) first_err_addr <= mm_addr;
      end
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= WAIT_INIT;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            woff           <= '0;
            roff           <= '0;
            coff           <= '0;
            beat           <= '0;
            outst          <= '0;
            mm_q           <= 1'b0;
          end
        end
        WAIT_INIT: begin
          if (local_init_done) begin
            state            <= WRITE;
            local_write_req  <= 1'b1;
            local_burstbegin <= 1'b1;
            local_address    <= waddr('0);
            local_wdata      <= pat('0);
          end
        end
        WRITE: begin
          if (wr_acc) begin
            if (woff == LAST_W) begin
              state            <= READ;
              local_write_req  <= 1'b0;
              local_burstbegin <= 1'b0;
            end else begin
              woff        <= woff + CW'(1);
              local_wdata <= pat(woff + CW'(1));
              if (beat == BEAT_L) begin
                beat             <= '0;
                local_burstbegin <= 1'b1;
                local_address    <= waddr(woff + CW'(1));
              end else begin
                beat             <= beat + 2'd1;
                local_burstbegin <= 1'b0;
              end
            end
          end
        end
        READ: begin
          if (rd_acc) begin
            if (roff == LAST_R) begin
              state            <= DRAIN;
              local_read_req   <= 1'b0;
              local_burstbegin <= 1'b0;
            end else begin
              roff             <= roff + BL_C;
              local_address    <= waddr(roff + BL_C);
              local_read_req   <= rd_ok;
              local_burstbegin <= rd_ok;
            end
          end else if (!local_read_req && rd_ok) begin
            local_read_req   <= 1'b1;
            local_burstbegin <= 1'b1;
            local_address    <= waddr(roff);
          end
        end
        DRAIN: begin
          // the last compare result is folded in on this same edge
          if (outst == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mm_q;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_local_test_master.sv
// Bench for ddr2_local_test_master: memory model with random stalls
// and latency, checking request stream and run result.
module tb_ddr2_local_test_master;

  localparam logic [25:0] BASE = 26'h3FF_FFFC;
  localparam int          NW   = 16;
  localparam int          BL   = 2;
  localparam int          MAXO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        init_done;
  logic        ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic [25:0] addr;
  logic        wr;
  logic        rd;
  logic        bb;
  logic [2:0]  size;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] errc;
  logic [25:0] ferr;

  int checks = 0;
  int failures = 0;

  ddr2_local_test_master #(
    .ADDR_W(26), .DATA_W(32), .BURST_LEN(BL), .BASE_ADDR(BASE),
    .N_WORDS(NW), .MAX_OUTST(MAXO), .SEED(32'h5A5A_0000)
  ) dut (
    .phy_clk(clk), .reset_phy_clk_n(rst_n), .start(start),
    .local_init_done(init_done), .local_ready(ready),
    .local_rdata(rdata), .local_rdata_valid(rvalid),
    .local_address(addr), .local_write_req(wr), .local_read_req(rd),
    .local_burstbegin(bb), .local_size(size), .local_be(be),
    .local_wdata(wdata), .busy(busy), .done(done), .pass(pass),
    .err_count(errc), .first_err_addr(ferr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input logic [25:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  typedef struct {
    int          due;
    logic [25:0] a;
  } beat_t;

  logic [31:0] mem [logic [25:0]];
  beat_t       rq[$];
  int          cyc = 0;
  int          lat = 1;
  int          rdy_pct = 100;
  bit          flip_en = 0;
  logic [25:0] flip_addr = 26'd5;
  int          n_wr, n_rd, n_rv, outs, peak, req_seen;
  int          stab_err, order_err, overlap_err;
  int          first_wr, last_wr, exp_err;
  logic [25:0] exp_first;
  logic [25:0] wbase;
  int          wbeat;
  bit          p_hold;
  logic [25:0] p_addr;
  logic [31:0] p_wdata;
  logic        p_bb, p_wr, p_rd;

  task automatic clr();
    n_wr = 0; n_rd = 0; n_rv = 0; outs = 0; peak = 0; req_seen = 0;
    stab_err = 0; order_err = 0; overlap_err = 0;
    first_wr = 0; last_wr = 0; exp_err = 0; exp_first = '0;
    wbase = '0; wbeat = 0;
  endtask

  // Memory/controller model: inputs change at negedge, DUT samples at posedge
  always @(negedge clk) begin
    logic [25:0] a;
    logic [31:0] d;
    cyc++;
    if (!rst_n) begin
      rq.delete();
      ready  = 1'b0;
      rvalid = 1'b0;
      rdata  = '0;
      p_hold = 1'b0;
    end else begin
      ready = ($urandom_range(99) < rdy_pct);
      if (p_hold && (addr !== p_addr || wdata !== p_wdata ||
          bb !== p_bb || wr !== p_wr || rd !== p_rd))
        stab_err++;
      if (wr || rd) req_seen++;
      if (wr && rd) overlap_err++;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        a = rq[0].a;
        void'(rq.pop_front());
        d = mem.exists(a) ? mem[a] : 32'h0;
        if (flip_en && a == flip_addr) d = d ^ 32'h1;
        rdata  = d;
        rvalid = 1'b1;
        n_rv++;
        outs--;
        if (d !== pattern(a)) begin
          if (exp_err == 0) exp_first = a;
          exp_err++;
        end
      end else begin
        rvalid = 1'b0;
        rdata  = $urandom;
      end
      if (wr && ready) begin
        if (bb) begin
          wbase = addr;
          wbeat = 0;
        end else begin
          wbeat++;
        end
        a = wbase + 26'(wbeat);
        if (a != BASE + 26'(n_wr) || wbeat >= BL ||
            wdata !== pattern(a) || n_rd > 0)
          order_err++;
        mem[a] = wdata;
        if (n_wr == 0) first_wr = cyc;
        last_wr = cyc;
        n_wr++;
      end
      if (rd && ready) begin
        if (!bb || addr != BASE + 26'(n_rd * BL) || n_wr != NW)
          order_err++;
        for (int i = 0; i < BL; i++)
          rq.push_back('{due: cyc + lat + i, a: addr + 26'(i)});
        n_rd++;
        outs += BL;
      end
      if (outs > peak) peak = outs;
      p_hold  = (wr || rd) && !ready;
      p_addr  = addr;
      p_wdata = wdata;
      p_bb    = bb;
      p_wr    = wr;
      p_rd    = rd;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(output bit to);
    to = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic run(input int l, input int p, input bit fe,
                     output bit to);
    lat = l; rdy_pct = p; flip_en = fe;
    clr();
    pulse_start();
    wait_done(to);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (wr !== 1'b0) begin failures++; $display("FAIL rst_wr got %0b want 0", wr); end
    checks++; if (rd !== 1'b0) begin failures++; $display("FAIL rst_rd got %0b want 0", rd); end
    checks++; if (addr !== 26'd0) begin failures++; $display("FAIL rst_addr got %0h want 0", addr); end
    checks++; if (size !== 3'd2) begin failures++; $display("FAIL rst_size got %0d want 2", size); end
    checks++; if (be !== 4'hF) begin failures++; $display("FAIL rst_be got %0h want f", be); end
    checks++; if ({busy, done, pass} !== 3'b000) begin failures++; $display("FAIL rst_flags got %b want 000", {busy, done, pass}); end
    checks++; if (errc !== 16'd0) begin failures++; $display("FAIL rst_err got %0d want 0", errc); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ideal();
    bit to;
    run(1, 100, 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL ideal_timeout got busy=%0b want done", busy); end
    checks++; if (n_wr != NW) begin failures++; $display("FAIL ideal_nwr got %0d want %0d", n_wr, NW); end
    checks++; if (last_wr - first_wr != NW - 1) begin failures++; $display("FAIL ideal_wr_span got %0d want %0d", last_wr - first_wr, NW - 1); end
    checks++; if (n_rd != NW / BL) begin failures++; $display("FAIL ideal_nrd got %0d want %0d", n_rd, NW / BL); end
    checks++; if (order_err != 0) begin failures++; $display("FAIL ideal_order got %0d want 0", order_err); end
    checks++; if (pass !== 1'b1 || errc !== 16'd0) begin failures++; $display("FAIL ideal_pass got pass=%0b err=%0d want 1/0", pass, errc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ideal_busy got %0b want 0", busy); end
  endtask

  task automatic test_error();
    bit to;
    run(3, 100, 1'b1, to);
    checks++; if (to) begin failures++; $display("FAIL err_timeout got busy=%0b want done", busy); end
    checks++; if (errc !== 16'd1 || exp_err != 1) begin failures++; $display("FAIL err_count got %0d (model %0d) want 1", errc, exp_err); end
    checks++; if (ferr !== 26'd5) begin failures++; $display("FAIL err_first got %0h want 5", ferr); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL err_pass got %0b want 0", pass); end
  endtask

  task automatic test_stall();
    bit to;
    for (int r = 0; r < 3; r++) begin
      run($urandom_range(6, 1), 50, 1'b0, to);
      checks++; if (to) begin failures++; $display("FAIL stall_timeout got busy=%0b want done", busy); end
      checks++; if (stab_err != 0) begin failures++; $display("FAIL stall_stable got %0d want 0", stab_err); end
      checks++; if (n_wr != NW || n_rv != NW || order_err != 0) begin failures++; $display("FAIL stall_beats got wr=%0d rv=%0d ord=%0d want %0d/%0d/0", n_wr, n_rv, order_err, NW, NW); end
      checks++; if (overlap_err != 0) begin failures++; $display("FAIL stall_overlap got %0d want 0", overlap_err); end
      checks++; if (pass !== 1'b1 || errc != 16'(exp_err)) begin failures++; $display("FAIL stall_pass got pass=%0b err=%0d want 1/%0d", pass, errc, exp_err); end
    end
  endtask

  task automatic test_latency();
    bit to;
    run(20, 100, 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL lat_timeout got busy=%0b want done", busy); end
    checks++; if (peak != MAXO) begin failures++; $display("FAIL lat_peak got %0d want %0d", peak, MAXO); end
    checks++; if (pass !== 1'b1 || n_rd != NW / BL) begin failures++; $display("FAIL lat_pass got pass=%0b nrd=%0d want 1/%0d", pass, n_rd, NW / BL); end
  endtask

  task automatic test_init_wait();
    bit to;
    lat = 2; rdy_pct = 100; flip_en = 1'b0;
    clr();
    init_done = 1'b0;
    pulse_start();
    repeat (100) @(negedge clk);
    checks++; if (req_seen != 0) begin failures++; $display("FAIL init_noreq got %0d want 0", req_seen); end
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL init_busy got busy=%0b done=%0b want 1/0", busy, done); end
    pulse_start();
    init_done = 1'b1;
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done(to);
    checks++; if (to) begin failures++; $display("FAIL init_timeout got busy=%0b want done", busy); end
    checks++; if (n_wr != NW || n_rd != NW / BL || order_err != 0) begin failures++; $display("FAIL init_counts got wr=%0d rd=%0d ord=%0d want %0d/%0d/0", n_wr, n_rd, order_err, NW, NW / BL); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL init_pass got %0b want 1", pass); end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit hit;
    lat = 6; rdy_pct = 100; flip_en = 1'b0;
    clr();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (n_rd >= 2 && rd === 1'b1) hit = 1'b1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL mid_reach got rd_count=%0d want >=2", n_rd); end
    rst_n = 1'b0;
    #1;
    checks++; if ({wr, rd, bb, busy, done, pass} !== 6'b0) begin failures++; $display("FAIL mid_flags got %b want 000000", {wr, rd, bb, busy, done, pass}); end
    checks++; if (addr !== 26'd0 || wdata !== 32'd0 || size !== 3'd2 || be !== 4'hF) begin failures++; $display("FAIL mid_outs got a=%0h d=%0h s=%0d be=%0h want 0/0/2/f", addr, wdata, size, be); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(2, 70, 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL wrap_timeout got busy=%0b want done", busy); end
    checks++; if (order_err != 0 || n_rv != NW) begin failures++; $display("FAIL wrap_order got ord=%0d rv=%0d want 0/%0d", order_err, n_rv, NW); end
    checks++; if (mem[26'h3FF_FFFF] !== pattern(26'h3FF_FFFF) || mem[26'd0] !== pattern(26'd0)) begin failures++; $display("FAIL wrap_mem got %0h/%0h want %0h/%0h", mem[26'h3FF_FFFF], mem[26'd0], pattern(26'h3FF_FFFF), pattern(26'd0)); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL wrap_pass got %0b want 1", pass); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    init_done = 1'b1;
    clr();
    test_reset();
    test_ideal();
    test_error();
    test_stall();
    test_latency();
    test_init_wait();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
